// File: rtl/fan_speed_sequencer_if.sv
// ----------------------------------------------------------------------------
// fan_speed_sequencer_if
// Bundles the button inputs and the selection outputs of the fan speed
// sequencer so they travel as one port.
//
// Signals:
//   i_button [4:0]  single-cycle debounced pulses: [0] power, [1] up,
//                   [2] down, [3] timer, [4] auto
//   o_sel    [5:0]  speed select (0 off, 1..3 speed, 4/5 down-ramp speeds)
//   o_sec    [6:0]  remaining off-timer seconds, 0 = timer disabled
//   o_mode   [1:0]  0 = OFF, 1 = MANUAL, 2 = AUTO
//   o_tick          one-cycle pulse at each one-second boundary
//
// Modports:
//   master  drives the buttons and observes the outputs (button logic / bench)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface fan_speed_sequencer_if;
    logic [4:0] i_button;
    logic [5:0] o_sel;
    logic [6:0] o_sec;
    logic [1:0] o_mode;
    logic       o_tick;

    modport master (
        output i_button,
        input  o_sel,
        input  o_sec,
        input  o_mode,
        input  o_tick
    );

    modport slave (
        input  i_button,
        output o_sel,
        output o_sec,
        output o_mode,
        output o_tick
    );
endinterface

// File: rtl/fan_speed_sequencer.sv
// ----------------------------------------------------------------------------
// fan_speed_sequencer
// Control-side driver of the fan PWM selection path. Turns debounced button
// pulses into manual speed changes, an automatic "natural wind" ramp
// (1 -> 2 -> 3 -> 2 -> 1 ...) and a countdown off-timer driven by a
// one-second tick derived from the system clock.
//
// Parameters:
//   TICK_DIV       clock cycles per one-second tick
//   AUTO_STEP_SEC  seconds spent at each select value in AUTO mode
//   TIMER_STEP     seconds added per timer-button press
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-high reset
//   if_fan  slave side of fan_speed_sequencer_if (i_button in;
//           o_sel, o_sec, o_mode, o_tick out, all registered)
// ----------------------------------------------------------------------------
module fan_speed_sequencer #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int AUTO_STEP_SEC = 2,
    parameter int TIMER_STEP    = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    fan_speed_sequencer_if.slave        if_fan
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (AUTO_STEP_SEC > 1) ? $clog2(AUTO_STEP_SEC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(AUTO_STEP_SEC - 1);
    localparam logic [7:0]    SEC_MAX    = 8'd120;
    localparam logic [7:0]    SEC_STEP   = 8'(TIMER_STEP);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_AUTO   = 2'd2
    } mode_t;

    logic [PW-1:0] r_presc;
    logic          r_tick;
    mode_t         r_mode;
    logic [5:0]    r_sel;
    logic [6:0]    r_sec;
    logic [SW-1:0] r_step;

    logic [PW-1:0] w_prescNext;
    logic [4:0]    w_btn;
    logic [7:0]    w_secSum;
    logic [6:0]    w_secPress;
    logic [5:0]    w_baseSel;
    logic [5:0]    w_selUp;
    logic [5:0]    w_selDown;
    logic [5:0]    w_selRamp;

    mode_t         w_mode;
    logic [5:0]    w_sel;
    logic [6:0]    w_sec;
    logic [SW-1:0] w_step;

    // Free-running prescaler. The tick flop is loaded with the compare of the
    // next count, so o_tick is high exactly while r_presc == TICK_DIV-1.
    assign w_prescNext = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_prescNext;
            r_tick  <= (w_prescNext == PRESC_LAST);
        end
    end

    // Isolate the lowest set button bit so simultaneous presses resolve to
    // the lowest index.
    assign w_btn = if_fan.i_button & (~if_fan.i_button + 5'd1);

    // Sum is one bit wider so a press near the top cannot alias below 120.
    assign w_secSum   = {1'b0, r_sec} + SEC_STEP;
    assign w_secPress = (w_secSum > SEC_MAX) ? 7'd0 : w_secSum[6:0];

    // Down-ramp selects fold back onto their manual speeds before any
    // up/down step is applied; in MANUAL r_sel is already 1..3.
    always_comb begin
        case (r_sel)
            6'd4:    w_baseSel = 6'd2;
            6'd5:    w_baseSel = 6'd1;
            default: w_baseSel = r_sel;
        endcase
    end

    assign w_selUp   = (w_baseSel >= 6'd3) ? 6'd3 : w_baseSel + 6'd1;
    assign w_selDown = (w_baseSel <= 6'd1) ? 6'd1 : w_baseSel - 6'd1;

    // Button stage: the state after honouring this cycle's button pulse,
    // before the one-second effects are layered on top.
    always_comb begin
        w_mode = r_mode;
        w_sel  = r_sel;
        w_sec  = r_sec;
        w_step = r_step;
        case (r_mode)
            MODE_OFF: begin
                w_sel = 6'd0;
                w_sec = 7'd0;
                if (w_btn[0]) begin
                    w_mode = MODE_MANUAL;
                    w_sel  = 6'd1;
                end else if (w_btn[4]) begin
                    w_mode = MODE_AUTO;
                    w_sel  = 6'd1;
                    w_step = '0;
                end
            end
            MODE_MANUAL: begin
                if (w_btn[0]) begin
                    w_mode = MODE_OFF;
                    w_sel  = 6'd0;
                    w_sec  = 7'd0;
                end else if (w_btn[1]) begin
                    w_sel = w_selUp;
                end else if (w_btn[2]) begin
                    w_sel = w_selDown;
                end else if (w_btn[3]) begin
                    w_sec = w_secPress;
                end else if (w_btn[4]) begin
                    w_mode = MODE_AUTO;
                    w_step = '0;
                end
            end
            MODE_AUTO: begin
                if (w_btn[0]) begin
                    w_mode = MODE_OFF;
                    w_sel  = 6'd0;
                    w_sec  = 7'd0;
                end else if (w_btn[1]) begin
                    w_mode = MODE_MANUAL;
                    w_sel  = w_selUp;
                end else if (w_btn[2]) begin
                    w_mode = MODE_MANUAL;
                    w_sel  = w_selDown;
                end else if (w_btn[3]) begin
                    w_sec = w_secPress;
                end else if (w_btn[4]) begin
                    w_mode = MODE_MANUAL;
                    w_sel  = w_baseSel;
                end
            end
            default: begin
                w_mode = MODE_OFF;
                w_sel  = 6'd0;
                w_sec  = 7'd0;
            end
        endcase
    end

    assign w_selRamp = (w_sel >= 6'd5) ? 6'd1 : w_sel + 6'd1;

    // State register. The tick effects (ramp step, countdown, expiry) act on
    // the post-button values, so a press and a tick in the same cycle apply
    // in that order; a power press that reaches OFF skips the tick entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= MODE_OFF;
            r_sel  <= 6'd0;
            r_sec  <= 7'd0;
            r_step <= '0;
        end else begin
            r_mode <= w_mode;
            r_sel  <= w_sel;
            r_sec  <= w_sec;
            r_step <= w_step;
            if (r_tick && (w_mode != MODE_OFF)) begin
                if (w_mode == MODE_AUTO) begin
                    if (w_step == STEP_LAST) begin
                        r_step <= '0;
                        r_sel  <= w_selRamp;
                    end else begin
                        r_step <= w_step + 1'b1;
                    end
                end
                if (w_sec != 7'd0) begin
                    r_sec <= w_sec - 7'd1;
                    if (w_sec == 7'd1) begin
                        r_mode <= MODE_OFF;
                        r_sel  <= 6'd0;
                    end
                end
            end
        end
    end

    assign if_fan.o_sel  = r_sel;
    assign if_fan.o_sec  = r_sec;
    assign if_fan.o_mode = r_mode;
    assign if_fan.o_tick = r_tick;

endmodule

// File: tb/tb_fan_speed_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fan_speed_sequencer
// Directed test of fan_speed_sequencer with TICK_DIV=4, AUTO_STEP_SEC=2,
// TIMER_STEP=20. Buttons are driven on the falling edge for one cycle and
// outputs are sampled on the falling edge. A free-running cycle counter in
// the bench gives the prescaler phase, so every press lands on a known
// tick/non-tick cycle and the expected values below are worked out by hand.
// ----------------------------------------------------------------------------
module tb_fan_speed_sequencer;

    localparam int TICK_DIV      = 4;
    localparam int AUTO_STEP_SEC = 2;
    localparam int TIMER_STEP    = 20;

    localparam logic [4:0] BTN_POWER = 5'b00001;
    localparam logic [4:0] BTN_UP    = 5'b00010;
    localparam logic [4:0] BTN_DOWN  = 5'b00100;
    localparam logic [4:0] BTN_TIMER = 5'b01000;
    localparam logic [4:0] BTN_AUTO  = 5'b10000;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   errorCount = 0;
    int   cycCnt;

    fan_speed_sequencer_if fanIf ();

    fan_speed_sequencer #(
        .TICK_DIV      (TICK_DIV),
        .AUTO_STEP_SEC (AUTO_STEP_SEC),
        .TIMER_STEP    (TIMER_STEP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .if_fan (fanIf)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was last released; the prescaler phase
    // is cycCnt mod TICK_DIV.
    always @(posedge clk or posedge reset) begin
        if (reset) cycCnt <= 0;
        else       cycCnt <= cycCnt + 1;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input int mode, input int sel, input int sec);
        checkOutput({tag, " mode"}, int'(fanIf.o_mode), mode);
        checkOutput({tag, " sel"},  int'(fanIf.o_sel),  sel);
        checkOutput({tag, " sec"},  int'(fanIf.o_sec),  sec);
    endtask

    // Called on a falling edge; holds the pattern for exactly one cycle.
    task automatic applyStimulus(input logic [4:0] btn);
        fanIf.i_button = btn;
        @(negedge clk);
        fanIf.i_button = 5'd0;
    endtask

    task automatic waitPhase(input int phase);
        int guard = 0;
        while (((cycCnt % TICK_DIV) != phase) && (guard < 2 * TICK_DIV)) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // The tick must be high exactly in the last cycle of every prescaler period.
    always @(negedge clk) begin
        checkOutput("tick", int'(fanIf.o_tick), ((cycCnt % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int upExp[3]     = '{2, 3, 3};
        int downExp[4]   = '{2, 1, 1, 1};
        int rampExp[5]   = '{2, 3, 4, 5, 1};
        int timerExp[7]  = '{20, 40, 60, 79, 99, 119, 0};
        int climbExpA[3] = '{20, 40, 60};
        int climbExpB[3] = '{79, 99, 119};
        int n;

        fanIf.i_button = 5'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkState("reset", 0, 0, 0);
        checkOutput("reset tick", int'(fanIf.o_tick), 0);
        reset = 1'b0;

        // Manual speed control with saturation at both ends.
        applyStimulus(BTN_POWER);
        checkState("power on", 1, 1, 0);
        foreach (upExp[i]) begin
            applyStimulus(BTN_UP);
            checkState($sformatf("up %0d", i), 1, upExp[i], 0);
        end
        foreach (downExp[i]) begin
            applyStimulus(BTN_DOWN);
            checkState($sformatf("down %0d", i), 1, downExp[i], 0);
        end
        applyStimulus(BTN_POWER | BTN_UP);
        checkState("power+up", 0, 0, 0);
        applyStimulus(BTN_UP);
        checkState("off up", 0, 0, 0);
        applyStimulus(BTN_TIMER);
        checkState("off timer", 0, 0, 0);

        // AUTO ramp: two ticks (8 cycles) per select value.
        waitPhase(0);
        applyStimulus(BTN_AUTO);
        checkState("auto enter", 2, 1, 0);
        foreach (rampExp[i]) begin
            repeat (8) @(negedge clk);
            checkState($sformatf("ramp %0d", i), 2, rampExp[i], 0);
        end
        repeat (32) @(negedge clk);
        checkState("ramp sel5", 2, 5, 0);
        applyStimulus(BTN_UP);
        checkState("auto5 up", 1, 2, 0);

        waitPhase(0);
        applyStimulus(BTN_AUTO);
        checkState("manual to auto", 2, 2, 0);
        repeat (16) @(negedge clk);
        checkState("ramp sel4", 2, 4, 0);
        applyStimulus(BTN_DOWN);
        checkState("auto4 down", 1, 1, 0);

        // Seven back-to-back timer presses; the fourth lands on a tick cycle.
        waitPhase(0);
        foreach (timerExp[i]) begin
            applyStimulus(BTN_TIMER);
            checkOutput($sformatf("timer press %0d", i), int'(fanIf.o_sec), timerExp[i]);
        end
        checkOutput("timer wrap mode", int'(fanIf.o_mode), 1);

        // Climb to exactly 100 so the next press reaches 120 without wrapping.
        waitPhase(0);
        foreach (climbExpA[i]) begin
            applyStimulus(BTN_TIMER);
            checkOutput($sformatf("climb a%0d", i), int'(fanIf.o_sec), climbExpA[i]);
        end
        @(negedge clk);
        checkOutput("climb tick", int'(fanIf.o_sec), 59);
        foreach (climbExpB[i]) begin
            applyStimulus(BTN_TIMER);
            checkOutput($sformatf("climb b%0d", i), int'(fanIf.o_sec), climbExpB[i]);
        end
        repeat (73) @(negedge clk);
        checkOutput("countdown to 100", int'(fanIf.o_sec), 100);
        applyStimulus(BTN_TIMER);
        checkState("timer 120", 1, 1, 120);
        applyStimulus(BTN_TIMER);
        checkState("timer 140 wraps", 1, 1, 0);

        // Full 20-second countdown ending in OFF on the expiry edge.
        applyStimulus(BTN_UP);
        checkState("up before expiry", 1, 2, 0);
        waitPhase(0);
        applyStimulus(BTN_TIMER);
        checkState("expiry arm", 1, 2, 20);
        repeat (78) @(negedge clk);
        checkState("expiry last second", 1, 2, 1);
        @(negedge clk);
        checkState("expiry", 0, 0, 0);

        // Timer press at sec=1 on the tick cycle gives 20, not OFF.
        applyStimulus(BTN_POWER);
        checkState("power again", 1, 1, 0);
        waitPhase(0);
        applyStimulus(BTN_TIMER);
        checkState("rearm", 1, 1, 20);
        repeat (78) @(negedge clk);
        checkState("sec one", 1, 1, 1);
        checkOutput("sec one tick", int'(fanIf.o_tick), 1);
        applyStimulus(BTN_TIMER);
        checkState("timer at tick", 1, 1, 20);

        // Power press coinciding with expiry stays OFF.
        repeat (79) @(negedge clk);
        checkState("sec one again", 1, 1, 1);
        applyStimulus(BTN_POWER);
        checkState("power at expiry", 0, 0, 0);

        // Asynchronous reset between edges in AUTO with 40 seconds pending.
        waitPhase(0);
        applyStimulus(BTN_AUTO);
        checkState("auto for reset", 2, 1, 0);
        applyStimulus(BTN_TIMER);
        checkState("reset arm 20", 2, 1, 20);
        applyStimulus(BTN_TIMER);
        checkState("reset arm 40", 2, 1, 40);
        #2 reset = 1'b1;
        #1;
        checkState("async reset", 0, 0, 0);
        checkOutput("async reset tick", int'(fanIf.o_tick), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Release cycle counts as the first; the tick occupies the TICK_DIV-th.
        n = 0;
        while ((fanIf.o_tick !== 1'b1) && (n < 4 * TICK_DIV)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first tick after release", n, TICK_DIV - 1);
        checkState("after release", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
